lcd_driver_4bit: RTL and testbench

//  Physical-layer driver for the LCD 1602A in 4-bit mode. Sits directly downstream of the controller control FSM.

---
 rtl/lcd_driver_4bit.sv | 147 ++++++++++++++
 tb/tb_lcd_driver_4bit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_driver_4bit.sv
// lcd_driver_4bit: physical-layer driver for an HD44780-style 1602A LCD in 4-bit mode.
// Each transfer starts on a rising edge of drv_enable. It sends the latched byte as two
// nibbles, high nibble first, with E setup/pulse/hold framing and an inter-nibble gap.
// It then waits for the standard execution time and pulses driver_rdy.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   drv_enable           request; a transfer starts on its rising edge while idle
//   drv_data[7:0]        byte to send, sampled at start
//   drv_rs               register select for the byte, sampled at start
//   driver_rdy           one-cycle pulse when the transfer and execution wait are done
//   drv_busy             high from the cycle after start through the driver_rdy cycle
//   drv_overrun          one-cycle pulse for a rising edge of drv_enable while not idle
//   lcd_rs, lcd_rw       LCD register select, read/write (always write)
//   lcd_e, lcd_db[3:0]   LCD enable strobe and data bus DB[7:4]
module lcd_driver_4bit #(
   parameter int unsigned T_SETUP  = 2,
   parameter int unsigned T_PULSE  = 13,
   parameter int unsigned T_HOLD   = 2,
   parameter int unsigned T_NIBBLE = 50,
   parameter int unsigned T_EXEC   = 2100,
   parameter int unsigned CW       = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       drv_enable,
   input  logic [7:0] drv_data,
   input  logic       drv_rs,
   output logic       driver_rdy,
   output logic       drv_busy,
   output logic       drv_overrun,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [3:0] lcd_db
);

   typedef enum logic [3:0] {
      IDLE, SETUP_H, PULSE_H, HOLD_H, GAP, SETUP_L, PULSE_L, HOLD_L, EXEC, DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      data_q, data_d;
   logic            rs_q, rs_d;
   logic            en_q;
   logic            rise;
   logic            rdy_d, busy_d, ovr_d, lcd_rs_d, lcd_e_d;
   logic [3:0]      lcd_db_d;

   // Successor of each timed state.
   function automatic state_e next_timed(input state_e s);
      case (s)
         SETUP_H: return PULSE_H;
         PULSE_H: return HOLD_H;
         HOLD_H:  return GAP;
         GAP:     return SETUP_L;
         SETUP_L: return PULSE_L;
         PULSE_L: return HOLD_L;
         HOLD_L:  return EXEC;
         EXEC:    return DONE;
         default: return IDLE;
      endcase
   endfunction

   // Counter load on entry: duration minus one, so the state lasts exactly its duration.
   function automatic logic [CW-1:0] load_of(input state_e s);
      case (s)
         SETUP_H, SETUP_L: return CW'(T_SETUP - 1);
         PULSE_H, PULSE_L: return CW'(T_PULSE - 1);
         HOLD_H,  HOLD_L:  return CW'(T_HOLD - 1);
         GAP:              return CW'(T_NIBBLE - 1);
         EXEC:             return CW'(T_EXEC - 1);
         default:          return '0;
      endcase
   endfunction

   assign rise   = drv_enable & ~en_q;
   assign lcd_rw = 1'b0;

   // Next-state logic; outputs are derived from the next state so the pins are registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      rs_d    = rs_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = SETUP_H;
               cnt_d   = load_of(SETUP_H);
               data_d  = drv_data;
               rs_d    = drv_rs;
            end
         end
         DONE: state_d = IDLE;
         default: begin
            if (cnt_q == '0) begin
               state_d = next_timed(state_q);
               cnt_d   = load_of(state_d);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase

      rdy_d    = (state_d == DONE);
      busy_d   = (state_d != IDLE);
      ovr_d    = rise && (state_q != IDLE);
      lcd_e_d  = (state_d == PULSE_H) || (state_d == PULSE_L);
      lcd_rs_d = busy_d ? rs_d : 1'b0;
      case (state_d)
         SETUP_H, PULSE_H, HOLD_H, GAP: lcd_db_d = data_d[7:4];
         SETUP_L, PULSE_L, HOLD_L:      lcd_db_d = data_d[3:0];
         default:                       lcd_db_d = 4'h0;
      endcase
   end

   // State, timer, latches and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         rs_q        <= 1'b0;
         en_q        <= 1'b0;
         driver_rdy  <= 1'b0;
         drv_busy    <= 1'b0;
         drv_overrun <= 1'b0;
         lcd_rs      <= 1'b0;
         lcd_e       <= 1'b0;
         lcd_db      <= 4'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         en_q        <= drv_enable;
         driver_rdy  <= rdy_d;
         drv_busy    <= busy_d;
         drv_overrun <= ovr_d;
         lcd_rs      <= lcd_rs_d;
         lcd_e       <= lcd_e_d;
         lcd_db      <= lcd_db_d;
      end
   end

endmodule

// File: tb/tb_lcd_driver_4bit.sv
// tb_lcd_driver_4bit: self-checking bench for lcd_driver_4bit.
// Instance u_dut uses short timing and is compared every cycle against a transfer-offset
// reference model. Instance u_def uses the default timing and has its waveform measured.
module tb_lcd_driver_4bit;

   localparam int unsigned S  = 1;
   localparam int unsigned P  = 2;
   localparam int unsigned H  = 1;
   localparam int unsigned N  = 3;
   localparam int unsigned X  = 4;
   localparam int unsigned B  = S + P + H + N;          // offset where the low nibble begins
   localparam int unsigned L  = 2 * (S + P + H) + N + X; // start edge to driver_rdy

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en, rs;
   logic [7:0] data;
   logic       rdy, busy, ovr, lrs, lrw, le;
   logic [3:0] ldb;

   logic       en2, rs2;
   logic [7:0] data2;
   logic       rdy2, busy2, ovr2, lrs2, lrw2, le2;
   logic [3:0] ldb2;

   lcd_driver_4bit #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_NIBBLE(N), .T_EXEC(X), .CW(12)) u_dut (
      .clk(clk), .rst_n(rst_n), .drv_enable(en), .drv_data(data), .drv_rs(rs),
      .driver_rdy(rdy), .drv_busy(busy), .drv_overrun(ovr),
      .lcd_rs(lrs), .lcd_rw(lrw), .lcd_e(le), .lcd_db(ldb)
   );

   lcd_driver_4bit u_def (
      .clk(clk), .rst_n(rst_n), .drv_enable(en2), .drv_data(data2), .drv_rs(rs2),
      .driver_rdy(rdy2), .drv_busy(busy2), .drv_overrun(ovr2),
      .lcd_rs(lrs2), .lcd_rw(lrw2), .lcd_e(le2), .lcd_db(ldb2)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: active transfer and its cycle offset since the start edge
   bit         m_active, m_prev_en, m_ovr, m_rs;
   int         m_k;
   logic [7:0] m_byte;

   // observation bookkeeping
   int         cyc, n_rdy, n_ovr, n_e_hi;
   bit         prev_e;
   logic [3:0] q_nib[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected {lcd_rs, lcd_rw, lcd_e, lcd_db} from the offset within a transfer.
   function automatic logic [6:0] exp_pins();
      logic [3:0] db;
      logic       e;
      if (!m_active) return 7'd0;
      if (m_k < int'(B))               db = m_byte[7:4];
      else if (m_k < int'(B + S + P + H)) db = m_byte[3:0];
      else                              db = 4'h0;
      e = (m_k >= int'(S) && m_k < int'(S + P)) || (m_k >= int'(B + S) && m_k < int'(B + S + P));
      return {m_rs, 1'b0, e, db};
   endfunction

   // One clock: advance the model at the edge, compare everything at the falling edge.
   task automatic cycle();
      bit rise, was_busy;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         m_active = 1'b0; m_prev_en = 1'b0; m_ovr = 1'b0;
      end else begin
         rise      = en && !m_prev_en;
         m_prev_en = en;
         was_busy  = m_active;
         if (m_active) begin
            m_k++;
            if (m_k > int'(L)) m_active = 1'b0;
         end
         m_ovr = rise && was_busy;
         if (rise && !was_busy) begin
            m_active = 1'b1; m_k = 0; m_byte = data; m_rs = rs;
         end
      end
      @(negedge clk);
      check("pins", 32'({lrs, lrw, le, ldb}), 32'(exp_pins()));
      check("status", 32'({rdy, busy, ovr}), 32'({m_active && (m_k == int'(L)), m_active, m_ovr}));
      if (le && !prev_e) q_nib.push_back(ldb);
      prev_e = le;
      n_rdy  += int'(rdy);
      n_ovr  += int'(ovr);
      n_e_hi += int'(le);
   endtask

   task automatic wait_rdy(input int max_cyc, output int at);
      at = -1;
      for (int i = 0; i < max_cyc; i++) begin
         cycle();
         if (rdy) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check("rdy_timeout", 32'd0, 32'd1);
   endtask

   task automatic clear_obs();
      q_nib.delete();
      n_rdy = 0; n_ovr = 0; n_e_hi = 0;
   endtask

   task automatic check_nibs(input string tag, input logic [3:0] hi, input logic [3:0] lo);
      check({tag, "_nib_count"}, 32'(q_nib.size()), 32'd2);
      if (q_nib.size() >= 2) begin
         check({tag, "_nib_hi"}, 32'(q_nib[0]), 32'(hi));
         check({tag, "_nib_lo"}, 32'(q_nib[1]), 32'(lo));
      end
   endtask

   logic [7:0] seq [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};

   initial begin
      int s, at;
      int rise1, fall1, rise2, rdy_k;
      logic [3:0] dhi, dlo;
      bit pe;

      rst_n = 1'b1; en = 1'b0; data = '0; rs = 1'b0;
      en2 = 1'b0; data2 = '0; rs2 = 1'b0;
      cyc = 0; prev_e = 1'b0;
      m_active = 1'b0; m_prev_en = 1'b0; m_ovr = 1'b0; m_rs = 1'b0; m_k = 0; m_byte = '0;
      clear_obs();

      // reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_pins", 32'({lrs, lrw, le, ldb}), 32'd0);
      check("rst_status", 32'({rdy, busy, ovr}), 32'd0);
      check("rst_def", 32'({rdy2, busy2, ovr2, lrs2, lrw2, le2, ldb2}), 32'd0);
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();

      // 1: single instruction byte
      clear_obs();
      data = 8'h28; rs = 1'b0; en = 1'b1;
      cycle(); s = cyc;
      wait_rdy(40, at);
      check("s1_latency", 32'(at - s), 32'(L));
      en = 1'b0;
      repeat (3) cycle();
      check_nibs("s1", 4'h2, 4'h8);
      check("s1_e_cycles", 32'(n_e_hi), 32'(2 * P));
      check("s1_rdy_count", 32'(n_rdy), 32'd1);

      // 2: data byte with enable held high past completion
      clear_obs();
      data = 8'h41; rs = 1'b1; en = 1'b1;
      cycle();
      wait_rdy(40, at);
      repeat (10) cycle();
      check("s2_rdy_count", 32'(n_rdy), 32'd1);
      check_nibs("s2", 4'h4, 4'h1);
      en = 1'b0;
      cycle();

      // 3: back-to-back command sequence
      clear_obs();
      for (int i = 0; i < 4; i++) begin
         data = seq[i]; rs = 1'b0; en = 1'b1;
         wait_rdy(40, at);
         en = 1'b0;
         cycle();
      end
      check("s3_rdy_count", 32'(n_rdy), 32'd4);
      check("s3_nib_count", 32'(q_nib.size()), 32'd8);
      for (int i = 0; i < 4 && q_nib.size() >= 8; i++) begin
         dhi = seq[i][7:4]; dlo = seq[i][3:0];
         check("s3_nib_hi", 32'(q_nib[2*i]), 32'(dhi));
         check("s3_nib_lo", 32'(q_nib[2*i+1]), 32'(dlo));
      end

      // 4: retrigger mid-transfer
      clear_obs();
      data = 8'hC3; rs = 1'b1; en = 1'b1;
      repeat (3) cycle();
      en = 1'b0; cycle();
      en = 1'b1; data = 8'hFF; rs = 1'b0; cycle();
      wait_rdy(40, at);
      en = 1'b0; repeat (3) cycle();
      check("s4_overrun_count", 32'(n_ovr), 32'd1);
      check("s4_rdy_count", 32'(n_rdy), 32'd1);
      check_nibs("s4", 4'hC, 4'h3);

      // 5: reset during the low-nibble pulse
      clear_obs();
      data = 8'h9B; rs = 1'b1; en = 1'b1;
      for (int i = 0; i < 40 && q_nib.size() < 2; i++) cycle();
      check("s5_in_pulse_l", 32'(le), 32'd1);
      #2 rst_n = 1'b0; en = 1'b0;
      #1;
      check("s5_async_pins", 32'({lrs, lrw, le, ldb}), 32'd0);
      check("s5_async_status", 32'({rdy, busy, ovr}), 32'd0);
      prev_e = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();
      check("s5_no_rdy", 32'(n_rdy), 32'd0);
      clear_obs();
      data = 8'h28; rs = 1'b0; en = 1'b1;
      cycle(); s = cyc;
      wait_rdy(40, at);
      check("s5_latency", 32'(at - s), 32'(L));
      en = 1'b0; cycle();
      check_nibs("s5", 4'h2, 4'h8);

      // randomized enable/data traffic against the model
      clear_obs();
      for (int i = 0; i < 800; i++) begin
         en   = ($urandom_range(0, 9) < 7);
         data = 8'($urandom);
         rs   = 1'($urandom_range(0, 1));
         cycle();
      end
      en = 1'b0;
      repeat (20) cycle();
      check("rand_idle", 32'({busy, le}), 32'd0);

      // 6: default timing
      data2 = 8'h5A; rs2 = 1'b1; en2 = 1'b1;
      rise1 = -1; fall1 = -1; rise2 = -1; rdy_k = -1; dhi = '0; dlo = '0; pe = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (le2 && !pe) begin
            if (rise1 < 0) begin
               rise1 = k; dhi = ldb2;
               check("d_rs", 32'({lrs2, lrw2, busy2}), 32'b101);
            end else begin
               rise2 = k; dlo = ldb2;
            end
         end
         if (!le2 && pe && fall1 < 0) fall1 = k;
         pe = le2;
         if (ovr2) check("d_overrun", 32'(ovr2), 32'd0);
         if (rdy2) begin
            rdy_k = k;
            break;
         end
      end
      en2 = 1'b0;
      check("d_setup", 32'(rise1), 32'd2);
      check("d_e_width", 32'(fall1 - rise1), 32'd13);
      check("d_e_low_between", 32'(rise2 - fall1), 32'd54);
      check("d_latency", 32'(rdy_k), 32'd2184);
      check("d_nib_hi", 32'(dhi), 32'h5);
      check("d_nib_lo", 32'(dlo), 32'hA);
      @(negedge clk);
      check("d_rdy_pulse", 32'({rdy2, busy2}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
